// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache: direct-mapped, read-only instruction cache for the fetch stage.
// A hit returns the instruction combinationally from pc_i. A miss stalls fetch
// while the line-fill FSM requests the whole line and writes the beats in order.
// Optional feature: define ICACHE_STATS_EN to add the hit_count_o/miss_count_o ports.
module ucsbece154b_icache #(
  parameter int NUM_SETS       = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int OFF  = $clog2(WORDS_PER_LINE);
  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = 32 - OFF - IDX - 2;
  localparam logic [31:0]    NOP       = 32'h0000_0013;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  state_t state, nextState;

  // Per-set storage.
  logic [NUM_SETS-1:0] valid;
  logic [TAGW-1:0]     tagArr  [NUM_SETS];
  logic [31:0]         dataArr [NUM_SETS][WORDS_PER_LINE];

  // Lookup address fields.
  logic [OFF-1:0]  pcOff;
  logic [IDX-1:0]  pcIdx;
  logic [TAGW-1:0] pcTag;
  logic            unusedPcBits;

  assign pcOff        = pc_i[OFF+1:2];
  assign pcIdx        = pc_i[OFF+IDX+1:OFF+2];
  assign pcTag        = pc_i[31:OFF+IDX+2];
  assign unusedPcBits = &{1'b0, pc_i[1:0]};

  // Fill bookkeeping: the line address latched at miss detection.
  logic [31:0]     lineAddr;
  logic [IDX-1:0]  fillIdx;
  logic [TAGW-1:0] fillTag;
  logic [OFF-1:0]  beatCnt;

  assign fillIdx    = lineAddr[OFF+IDX+1:OFF+2];
  assign fillTag    = lineAddr[31:OFF+IDX+2];
  assign mem_addr_o = lineAddr;

  logic hit, missStart, beatWe, lastBeat;

  // A partial line never hits: its valid bit is only set on the last beat.
  assign hit = (state == IDLE) && valid[pcIdx] && (tagArr[pcIdx] == pcTag);

  // Next-state logic and outputs; reset forces stall/request low.
  // NOTE: every signal gets a default first so this block cannot infer a latch.
  always_comb begin
    nextState = state;
    missStart = 1'b0;
    beatWe    = 1'b0;
    lastBeat  = 1'b0;
    instr_o   = NOP;
    stall_o   = 1'b1;
    mem_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          instr_o = dataArr[pcIdx][pcOff];
          stall_o = 1'b0;
        end else begin
          missStart = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) nextState = FILL;
      end
      FILL: begin
        if (mem_rvalid_i) begin
          beatWe = 1'b1;
          if (beatCnt == LAST_BEAT) begin
            lastBeat  = 1'b1;
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      stall_o   = 1'b0;
      mem_req_o = 1'b0;
    end
  end

  // State register, miss address latch, beat counter and valid bits.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beatCnt  <= '0;
      lineAddr <= '0;
      valid    <= '0;
    end else begin
      state <= nextState;
      if (missStart) lineAddr <= {pc_i[31:OFF+2], (OFF+2)'(0)};
      if (state == REQ) beatCnt <= '0;
      if (beatWe) beatCnt <= beatCnt + OFF'(1);
      if (lastBeat) valid[fillIdx] <= 1'b1;
    end
  end

  // Tag and data writes during the fill.
  // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line can hit.
  always_ff @(posedge clk) begin
    if (beatWe && !reset) dataArr[fillIdx][beatCnt] <= mem_rdata_i;
    if (lastBeat && !reset) tagArr[fillIdx] <= fillTag;
  end

`ifdef ICACHE_STATS_EN
  // Wrapping hit/miss statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (hit) hit_count_o <= hit_count_o + 32'd1;
      if (missStart) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench for ucsbece154b_icache: a behavioural memory responder with
// configurable ready delay and beat gaps, and a scoreboard of expected fetch results.
module tb_ucsbece154b_icache;

  localparam int WPL = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic [31:0] instr_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  ucsbece154b_icache #(.NUM_SETS(8), .WORDS_PER_LINE(WPL)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count_o (hit_count_o),
    .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents seen by the responder and the scoreboard.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'h10) begin
      case (a[3:2])
        2'd0:    w = 32'h0050_0093;
        2'd1:    w = 32'h0010_0113;
        2'd2:    w = 32'h0020_81B3;
        default: w = 32'h0000_0013;
      endcase
    end else begin
      w = 32'hA000_0000 ^ a;
    end
    return w;
  endfunction

  // Responder controls (written only by the main process).
  int readyDelay = 0;
  int beatGap    = 0;
  int strayReqs  = 0;

  // Responder state (written only by the responder).
  logic [31:0] reqAddrLog [64];
  int          reqCount   = 0;
  int          holdErrors = 0;
  int          holdChecks = 0;
  int          strayDone  = 0;
  bit          reqSeen    = 0;
  logic [31:0] reqAddr;
  logic [31:0] fillAddr;
  int          waitCnt, beatsLeft, beatIdx, gapCnt;

  // Memory responder: drives ready/beats at the falling edge.
  initial begin
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    beatsLeft    = 0;
    forever begin
      @(negedge clk);
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (mem_req_o) begin
        if (!reqSeen) begin
          reqSeen = 1;
          reqAddr = mem_addr_o;
          waitCnt = 0;
        end else begin
          holdChecks++;
          if (mem_addr_o !== reqAddr) holdErrors++;
        end
        if (waitCnt >= readyDelay) begin
          mem_ready_i = 1'b1;
          reqSeen     = 0;
          reqAddrLog[reqCount % 64] = reqAddr;
          reqCount++;
          fillAddr  = reqAddr;
          beatsLeft = WPL;
          beatIdx   = 0;
          gapCnt    = 0;
        end else begin
          waitCnt++;
        end
      end else if (beatsLeft > 0) begin
        if (gapCnt >= beatGap) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = memWord(fillAddr + 32'(4 * beatIdx));
          beatIdx++;
          beatsLeft--;
          gapCnt = 0;
        end else begin
          gapCnt++;
        end
      end else if (strayReqs != strayDone) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        strayDone++;
      end
    end
  end

  logic [31:0] sbq[$];
  int          reqRead = 0;

  // Drive pc, push the expected instruction, pop/compare when the stall drops.
  task automatic fetch(input logic [31:0] pc, input int expStall, input string tag);
    int stalls = 0;
    logic [31:0] exp;
    pc_i = pc;
    sbq.push_back(memWord({pc[31:2], 2'b00}));
    forever begin
      @(negedge clk);
      if (!stall_o) begin
        exp = sbq.pop_front();
        check({tag, "_instr"}, instr_o, exp);
        break;
      end
      stalls++;
      if (stalls > 200) begin
        check({tag, "_timeout"}, 32'(stall_o), 32'd0);
        exp = sbq.pop_front();
        break;
      end
      @(posedge clk); #1;
    end
    if (expStall >= 0) check({tag, "_stall"}, 32'(stalls), 32'(expStall));
    @(posedge clk); #1;
  endtask

  task automatic expectReq(input string tag, input logic [31:0] addr);
    logic [31:0] got = 32'hFFFF_FFFF;
    if (reqRead < reqCount) begin
      got = reqAddrLog[reqRead % 64];
      reqRead++;
    end
    check(tag, got, addr);
  endtask

  initial begin
    reset = 1'b1;
    pc_i  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_instr", instr_o, NOP);
    check("rst_addr", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold miss with zero-wait memory, then hits on the rest of the line.
    fetch(32'h0, WPL + 2, "cold0");
    expectReq("cold_addr", 32'h0);
    fetch(32'h4, 0, "hit4");
    fetch(32'h8, 0, "hit8");
    fetch(32'hC, 0, "hitC");
`ifdef ICACHE_STATS_EN
    check("stats_hits", hit_count_o, 32'd4);
    check("stats_miss", miss_count_o, 32'd1);
`endif

    // Conflict miss on set 0, then the evicted line misses again.
    fetch(32'h80, WPL + 2, "conf80");
    expectReq("conf_addr80", 32'h80);
    fetch(32'h88, 0, "hit88");
    fetch(32'h0, WPL + 2, "conf0");
    expectReq("conf_addr0", 32'h0);

    // Backpressure: 3 wait cycles in REQ, 2-cycle gaps before each beat.
    readyDelay = 3;
    beatGap    = 2;
    fetch(32'h4C, 1 + 4 + WPL * 3, "bp4C");
    expectReq("bp_addr", 32'h40);
    check("bp_hold_checks", 32'(holdChecks), 32'd3);
    check("bp_hold_errors", 32'(holdErrors), 32'd0);
    fetch(32'h40, 0, "bp40");
    fetch(32'h44, 0, "bp44");
    fetch(32'h48, 0, "bp48");

    // Partial-line protection: slow fill of set 1 with pc held on it.
    readyDelay = 0;
    fetch(32'h14, 1 + 1 + WPL * 3, "part14");
    expectReq("part_addr", 32'h10);
    fetch(32'h1C, 0, "part1C");

    // Reset in the cycle carrying the last beat aborts the fill.
    beatGap = 0;
    pc_i    = 32'h24;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    strayReqs++;
    @(negedge clk);
    check("abort_req", 32'(mem_req_o), 32'd0);
    check("abort_stall", 32'(stall_o), 32'd1);
    check("abort_instr", instr_o, NOP);
    @(posedge clk); #1;
    fetch(32'h24, WPL + 1, "refill24");
    expectReq("abort_addr", 32'h20);
    expectReq("refill_addr", 32'h20);
    check("stray_sent", 32'(strayDone), 32'd1);
    fetch(32'h20, 0, "refill20");
    fetch(32'h2C, 0, "refill2C");

    // Every line loaded before the reset is invalid afterwards.
    fetch(32'h0, WPL + 2, "post0");
    expectReq("post_addr0", 32'h0);
    fetch(32'h40, WPL + 2, "post40");
    expectReq("post_addr40", 32'h40);
    check("req_count", 32'(reqCount), 32'(reqRead));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
